// File: rtl/retire_unit_pkg.sv
// ---------------------------------------------------------------------------
// retire_unit_pkg
// Shared types and constants for the retire stage and its neighbours.
//   - ROB index typedef used by the reorder buffer side of the pipeline.
//   - RetireLaneSt : per-lane retire bundle fields (physical-register fields
//                    are carried separately because their width follows the
//                    PHY_REG_NUM parameter of the instantiating module).
//   - RetireStateE : retire FSM states.
//   - ExcReportSt  : exception report handed to the CSR block.
// ---------------------------------------------------------------------------
package retire_unit_pkg;

    localparam int XLEN            = 32;
    localparam int ARCH_REG_W      = 5;
    localparam int ECODE_W         = 6;
    localparam int SUB_ECODE_W     = 9;
    localparam int PHY_REG_NUM_DEF = 64;
    localparam int PW              = $clog2(PHY_REG_NUM_DEF);

    // Reorder-buffer typedefs shared with the ROB.
    localparam int ROB_DEPTH = 32;
    localparam int ROB_IDX_W = $clog2(ROB_DEPTH);
    typedef logic [ROB_IDX_W-1:0] RobIdxT;

    typedef enum logic [1:0] {
        RS_IDLE    = 2'd0,
        RS_FLUSH   = 2'd1,
        RS_RECOVER = 2'd2
    } RetireStateE;

    typedef struct packed {
        logic [XLEN-1:0]        pc;
        logic                   exception;
        logic [ECODE_W-1:0]     ecode;
        logic [SUB_ECODE_W-1:0] sub_ecode;
        logic [XLEN-1:0]        error_vaddr;
        logic                   redirect;
        logic [XLEN-1:0]        br_target;
        logic                   is_store;
        logic                   dest_valid;
        logic [ARCH_REG_W-1:0]  arch_dest;
    } RetireLaneSt;

    typedef struct packed {
        logic                   valid;
        logic [ECODE_W-1:0]     ecode;
        logic [SUB_ECODE_W-1:0] sub_ecode;
        logic [XLEN-1:0]        era;
        logic [XLEN-1:0]        badv;
    } ExcReportSt;

endpackage

// File: rtl/retire_cut_logic.sv
// ---------------------------------------------------------------------------
// retire_cut_logic
// Combinational finder for the first lane that ends a retire bundle.
//   valid       : per-lane valid (only the contiguous prefix from lane 0 counts)
//   exception   : per-lane exception flag
//   redirect    : per-lane mispredict flag
//   retire_mask : lanes that actually retire (lanes before the cut, plus the
//                 cut lane itself when it is a redirect rather than an exception)
//   has_cut     : some live lane raised an exception or redirect
//   cut_idx     : index k of that lane
//   cut_is_exc  : the cut lane is an exception (exception wins over redirect)
// ---------------------------------------------------------------------------
module retire_cut_logic #(
    parameter  int WIDTH = 2,
    localparam int IW    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] valid,
    input  logic [WIDTH-1:0] exception,
    input  logic [WIDTH-1:0] redirect,
    output logic [WIDTH-1:0] retire_mask,
    output logic             has_cut,
    output logic [IW-1:0]    cut_idx,
    output logic             cut_is_exc
);

    logic prefix_run;
    logic blocked;

    always_comb begin
        prefix_run  = 1'b1;
        blocked     = 1'b0;
        retire_mask = '0;
        has_cut     = 1'b0;
        cut_idx     = '0;
        cut_is_exc  = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            // A hole in valid kills every higher lane, as does an earlier cut.
            prefix_run = prefix_run & valid[i];
            if (prefix_run && !blocked) begin
                if (exception[i]) begin
                    has_cut    = 1'b1;
                    cut_idx    = IW'(i);
                    cut_is_exc = 1'b1;
                    blocked    = 1'b1;
                end else begin
                    retire_mask[i] = 1'b1;
                    if (redirect[i]) begin
                        has_cut = 1'b1;
                        cut_idx = IW'(i);
                        blocked = 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/retire_unit.sv
// ---------------------------------------------------------------------------
// retire_unit
// Consumes the in-order retire bundle from the reorder buffer. Retired lanes
// update the architectural RAT, release stale physical registers and commit
// stores; an exception or mispredict triggers FLUSH then RECOVER.
// Ports:
//   clk, a_rst_n                 clock, asynchronous active-low reset
//   rt_*_i / rt_ready_o          retire bundle (RETIRE_WIDTH lanes) + accept
//   eentry_i                     exception entry PC from CSR
//   arat_we/waddr/wdata_o        ARAT write port per lane (registered)
//   free_valid/preg_o            free-list release per lane (registered)
//   sb_cmt_valid_o/ready_i       store-buffer commit handshake
//   flush_o, redirect_pc_o       one-cycle flush with restart PC
//   exc_*_o                      CSR exception report (with flush_o)
//   instret_o                    retired-instruction counter
// ---------------------------------------------------------------------------
module retire_unit
    import retire_unit_pkg::*;
#(
    parameter  int RETIRE_WIDTH   = 2,
    parameter  int PHY_REG_NUM    = 64,
    parameter  int RECOVER_CYCLES = 2,
    localparam int PREG_W         = $clog2(PHY_REG_NUM)
) (
    input  logic                             clk,
    input  logic                             a_rst_n,
    input  logic [RETIRE_WIDTH-1:0]          rt_valid_i,
    output logic                             rt_ready_o,
    input  logic [RETIRE_WIDTH*32-1:0]       rt_pc_i,
    input  logic [RETIRE_WIDTH-1:0]          rt_exception_i,
    input  logic [RETIRE_WIDTH*6-1:0]        rt_ecode_i,
    input  logic [RETIRE_WIDTH*9-1:0]        rt_sub_ecode_i,
    input  logic [RETIRE_WIDTH*32-1:0]       rt_error_vaddr_i,
    input  logic [RETIRE_WIDTH-1:0]          rt_redirect_i,
    input  logic [RETIRE_WIDTH*32-1:0]       rt_br_target_i,
    input  logic [RETIRE_WIDTH-1:0]          rt_is_store_i,
    input  logic [RETIRE_WIDTH-1:0]          rt_dest_valid_i,
    input  logic [RETIRE_WIDTH*5-1:0]        rt_arch_dest_i,
    input  logic [RETIRE_WIDTH*PREG_W-1:0]   rt_phy_dest_i,
    input  logic [RETIRE_WIDTH*PREG_W-1:0]   rt_old_phy_i,
    input  logic [31:0]                      eentry_i,
    output logic [RETIRE_WIDTH-1:0]          arat_we_o,
    output logic [RETIRE_WIDTH*5-1:0]        arat_waddr_o,
    output logic [RETIRE_WIDTH*PREG_W-1:0]   arat_wdata_o,
    output logic [RETIRE_WIDTH-1:0]          free_valid_o,
    output logic [RETIRE_WIDTH*PREG_W-1:0]   free_preg_o,
    output logic                             sb_cmt_valid_o,
    input  logic                             sb_cmt_ready_i,
    output logic                             flush_o,
    output logic [31:0]                      redirect_pc_o,
    output logic                             exc_valid_o,
    output logic [5:0]                       exc_ecode_o,
    output logic [8:0]                       exc_sub_ecode_o,
    output logic [31:0]                      exc_era_o,
    output logic [31:0]                      exc_badv_o,
    output logic [63:0]                      instret_o
);

    localparam int IW = (RETIRE_WIDTH > 1) ? $clog2(RETIRE_WIDTH) : 1;
    localparam int CW = $clog2(RECOVER_CYCLES + 1);

    RetireLaneSt             lane     [RETIRE_WIDTH];
    logic [PREG_W-1:0]       phy_dest [RETIRE_WIDTH];
    logic [PREG_W-1:0]       old_phy  [RETIRE_WIDTH];
    logic [RETIRE_WIDTH-1:0] lane_exc, lane_redir, lane_store, lane_dest_v;

    // Unpack the flat bundle into per-lane records.
    generate
        for (genvar gi = 0; gi < RETIRE_WIDTH; gi++) begin : g_lane
            assign lane[gi] = '{
                pc:          rt_pc_i[gi*32 +: 32],
                exception:   rt_exception_i[gi],
                ecode:       rt_ecode_i[gi*ECODE_W +: ECODE_W],
                sub_ecode:   rt_sub_ecode_i[gi*SUB_ECODE_W +: SUB_ECODE_W],
                error_vaddr: rt_error_vaddr_i[gi*32 +: 32],
                redirect:    rt_redirect_i[gi],
                br_target:   rt_br_target_i[gi*32 +: 32],
                is_store:    rt_is_store_i[gi],
                dest_valid:  rt_dest_valid_i[gi],
                arch_dest:   rt_arch_dest_i[gi*ARCH_REG_W +: ARCH_REG_W]
            };
            assign phy_dest[gi]    = rt_phy_dest_i[gi*PREG_W +: PREG_W];
            assign old_phy[gi]     = rt_old_phy_i[gi*PREG_W +: PREG_W];
            assign lane_exc[gi]    = lane[gi].exception;
            assign lane_redir[gi]  = lane[gi].redirect;
            assign lane_store[gi]  = lane[gi].is_store;
            assign lane_dest_v[gi] = lane[gi].dest_valid;
        end
    endgenerate

    logic [RETIRE_WIDTH-1:0] retire_mask;
    logic                    has_cut;
    logic [IW-1:0]           cut_idx;
    logic                    cut_is_exc;

    retire_cut_logic #(
        .WIDTH (RETIRE_WIDTH)
    ) u_cut (
        .valid       (rt_valid_i),
        .exception   (lane_exc),
        .redirect    (lane_redir),
        .retire_mask (retire_mask),
        .has_cut     (has_cut),
        .cut_idx     (cut_idx),
        .cut_is_exc  (cut_is_exc)
    );

    // Fields of the cut lane, feeding the redirect and exception report.
    logic [31:0] sel_pc, sel_br_target, sel_badv;
    logic [5:0]  sel_ecode;
    logic [8:0]  sel_sub_ecode;

    always_comb begin
        sel_pc        = lane[cut_idx].pc;
        sel_br_target = lane[cut_idx].br_target;
        sel_badv      = lane[cut_idx].error_vaddr;
        sel_ecode     = lane[cut_idx].ecode;
        sel_sub_ecode = lane[cut_idx].sub_ecode;
    end

    logic [RETIRE_WIDTH-1:0] wr_mask;
    logic                    has_store;
    logic                    accept;

    // An excepting lane never retires, so its store does not count here.
    assign wr_mask   = retire_mask & lane_dest_v;
    assign has_store = |(retire_mask & lane_store);
    assign accept    = rt_ready_o & rt_valid_i[0];

    // ---------------- FSM ----------------
    RetireStateE   state_reg, state_next;
    logic [CW-1:0] rec_cnt_reg, rec_cnt_next;

    always_ff @(posedge clk or negedge a_rst_n) begin
        if (!a_rst_n) begin
            state_reg   <= RS_IDLE;
            rec_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            rec_cnt_reg <= rec_cnt_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        rec_cnt_next   = rec_cnt_reg;
        rt_ready_o     = 1'b0;
        sb_cmt_valid_o = 1'b0;
        flush_o        = 1'b0;
        case (state_reg)
            RS_IDLE: begin
                // Held low during reset even though the state already reads IDLE.
                sb_cmt_valid_o = a_rst_n & has_store;
                rt_ready_o     = a_rst_n & ~(has_store & ~sb_cmt_ready_i);
                if (rt_ready_o && rt_valid_i[0] && has_cut) begin
                    state_next = RS_FLUSH;
                end
            end
            RS_FLUSH: begin
                flush_o      = 1'b1;
                state_next   = RS_RECOVER;
                rec_cnt_next = CW'(RECOVER_CYCLES - 1);
            end
            RS_RECOVER: begin
                if (rec_cnt_reg == '0) begin
                    state_next = RS_IDLE;
                end else begin
                    rec_cnt_next = rec_cnt_reg - CW'(1);
                end
            end
            default: begin
                state_next = RS_IDLE;
            end
        endcase
    end

    // ---------------- Registered effects ----------------
    logic [RETIRE_WIDTH-1:0] arat_we_reg;
    logic [RETIRE_WIDTH-1:0] free_valid_reg;
    logic [4:0]              arat_waddr_reg [RETIRE_WIDTH];
    logic [PREG_W-1:0]       arat_wdata_reg [RETIRE_WIDTH];
    logic [PREG_W-1:0]       free_preg_reg  [RETIRE_WIDTH];
    logic [31:0]             redirect_pc_reg;
    logic [63:0]             instret_reg;
    ExcReportSt              exc_reg;

    always_ff @(posedge clk or negedge a_rst_n) begin
        if (!a_rst_n) begin
            arat_we_reg     <= '0;
            free_valid_reg  <= '0;
            for (int i = 0; i < RETIRE_WIDTH; i++) begin
                arat_waddr_reg[i] <= '0;
                arat_wdata_reg[i] <= '0;
                free_preg_reg[i]  <= '0;
            end
            redirect_pc_reg <= '0;
            instret_reg     <= '0;
            exc_reg         <= '0;
        end else begin
            arat_we_reg    <= '0;
            free_valid_reg <= '0;
            exc_reg.valid  <= 1'b0;
            if (accept) begin
                arat_we_reg    <= wr_mask;
                free_valid_reg <= wr_mask;
                for (int i = 0; i < RETIRE_WIDTH; i++) begin
                    arat_waddr_reg[i] <= lane[i].arch_dest;
                    arat_wdata_reg[i] <= phy_dest[i];
                    free_preg_reg[i]  <= old_phy[i];
                end
                instret_reg <= instret_reg + 64'($countones(retire_mask));
                if (has_cut) begin
                    redirect_pc_reg <= cut_is_exc ? eentry_i : sel_br_target;
                    if (cut_is_exc) begin
                        exc_reg.valid     <= 1'b1;
                        exc_reg.ecode     <= sel_ecode;
                        exc_reg.sub_ecode <= sel_sub_ecode;
                        exc_reg.era       <= sel_pc;
                        exc_reg.badv      <= sel_badv;
                    end
                end
            end
        end
    end

    generate
        for (genvar gi = 0; gi < RETIRE_WIDTH; gi++) begin : g_out
            assign arat_waddr_o[gi*5 +: 5]          = arat_waddr_reg[gi];
            assign arat_wdata_o[gi*PREG_W +: PREG_W] = arat_wdata_reg[gi];
            assign free_preg_o[gi*PREG_W +: PREG_W]  = free_preg_reg[gi];
        end
    endgenerate

    assign arat_we_o       = arat_we_reg;
    assign free_valid_o    = free_valid_reg;
    assign redirect_pc_o   = redirect_pc_reg;
    assign instret_o       = instret_reg;
    assign exc_valid_o     = exc_reg.valid;
    assign exc_ecode_o     = exc_reg.ecode;
    assign exc_sub_ecode_o = exc_reg.sub_ecode;
    assign exc_era_o       = exc_reg.era;
    assign exc_badv_o      = exc_reg.badv;

endmodule

// File: doc/retire_unit.md
Name: retire_unit

Overview:
Sits directly downstream of the reorder buffer and consumes its in-order retire bundle (up to RETIRE_WIDTH lanes per cycle). Per retired lane it commits the destination mapping to the architectural RAT, releases the stale physical register to the free list, and hands the store to the store buffer. On an exception or mispredict redirect it runs a flush sequence: one-cycle flush pulse, redirect PC, CSR exception report, then a fixed recovery window.

Parameters:
RETIRE_WIDTH, 2, lanes per retire bundle
PHY_REG_NUM, 64, physical registers; PW = clog2(PHY_REG_NUM)
RECOVER_CYCLES, 2, cycles held in RECOVER after a flush (>=1)

Ports:
clk  in  1  clock
a_rst_n  in  1  asynchronous active-low reset
rt_valid_i  in  RETIRE_WIDTH  per-lane valid, contiguous from lane 0
rt_ready_o  out  1  bundle accepted this cycle
rt_pc_i  in  RETIRE_WIDTH*32  lane PC
rt_exception_i  in  RETIRE_WIDTH  lane raised exception
rt_ecode_i  in  RETIRE_WIDTH*6  exception code
rt_sub_ecode_i  in  RETIRE_WIDTH*9  exception sub-code
rt_error_vaddr_i  in  RETIRE_WIDTH*32  faulting address
rt_redirect_i  in  RETIRE_WIDTH  lane mispredicted
rt_br_target_i  in  RETIRE_WIDTH*32  correct target
rt_is_store_i  in  RETIRE_WIDTH  lane is a store
rt_dest_valid_i  in  RETIRE_WIDTH  lane writes a register
rt_arch_dest_i  in  RETIRE_WIDTH*5  architectural destination
rt_phy_dest_i  in  RETIRE_WIDTH*PW  new physical destination
rt_old_phy_i  in  RETIRE_WIDTH*PW  previous mapping
eentry_i  in  32  exception entry from CSR
arat_we_o  out  RETIRE_WIDTH  ARAT write enable
arat_waddr_o  out  RETIRE_WIDTH*5  ARAT index
arat_wdata_o  out  RETIRE_WIDTH*PW  ARAT data
free_valid_o  out  RETIRE_WIDTH  release old_phy
free_preg_o  out  RETIRE_WIDTH*PW  released register
sb_cmt_valid_o  out  1  commit oldest store-buffer entry
sb_cmt_ready_i  in  1  store buffer accepts commit
flush_o  out  1  pipeline flush pulse
redirect_pc_o  out  32  fetch restart PC, valid with flush_o
exc_valid_o  out  1  CSR exception report, same cycle as flush_o
exc_ecode_o / exc_sub_ecode_o / exc_era_o / exc_badv_o  out  6/9/32/32  exception info
instret_o  out  64  retired-instruction count

Behaviour:
- Reset: FSM=IDLE, all outputs and registered state 0; rt_ready_o is 0 in reset and 1 out of it (IDLE).
- FSM: IDLE, FLUSH, RECOVER. rt_ready_o = (state==IDLE) & ~(bundle has store & ~sb_cmt_ready_i).
- Lane cut: k = first lane with exception|redirect. Lanes 0..k-1 retire normally. Lane k: redirect retires (ARAT/free/store effects apply); exception does NOT retire (no ARAT, free or store effects). Lanes >k are ignored.
- Normal effects, all registered, 1-cycle latency after the accept edge:
  - dest_valid lanes: arat_we/waddr/wdata = arch_dest/phy_dest and free_valid/preg = old_phy.
  - Store: sb_cmt_valid_o is combinational, asserted while a valid store lane exists in IDLE. At most one store per bundle (guaranteed upstream). A blocked store stalls the whole bundle; no partial accept.
- Same arch_dest in two accepted lanes: both write; the higher lane wins in the ARAT. Both old_phy are freed.
- instret_o += number of retired lanes (excluding the excepting lane), 64-bit wrapping.
- Flush (accepted bundle contains cut lane k): next cycle state=FLUSH.
  - flush_o=1 for exactly one cycle.
  - redirect_pc_o = eentry_i (exception, sampled at the accept edge) else br_target[k].
  - On exception also: exc_valid_o=1, ecode/sub_ecode, era=pc[k], badv=error_vaddr[k].
  - Then RECOVER for RECOVER_CYCLES cycles (down-counter), then IDLE.
- Exception has priority over redirect within a lane.
- Async reset mid-FLUSH/RECOVER: return to IDLE immediately; flush_o deasserts asynchronously.
- rt_valid_i non-contiguous: lanes above the first 0 are ignored.

Decomposition:
- Shared package: RetireLaneSt (lane fields), RetireStateE, ExcReportSt, PW and ECODE/SUB_ECODE width constants, alongside the existing ROB typedefs.
- One sub-module: retire_cut_logic (combinational first-exception/redirect finder producing the lane mask and k).

Test Plan:
- 2 valid lanes, dest r3->p10 (old p5), r4->p11 (old p6) -> next cycle arat_we=2'b11, free p5,p6, instret 0->2.
- Lane0 store, sb_cmt_ready_i=0 for 3 cycles then 1 -> rt_ready_o low 3 cycles, single sb_cmt handshake, no ARAT write until accept.
- Lane0 exception ecode=0x8, pc=0x1c000100, eentry=0x1c008000 -> flush_o 1 cycle, redirect_pc 0x1c008000, era 0x1c000100, no free/ARAT, ready low 1+RECOVER_CYCLES cycles.
- Lane0 normal, lane1 redirect target 0x1c000200 -> both lanes retire, instret +2, flush_o with redirect_pc 0x1c000200, exc_valid_o=0.
- Both lanes write r7 (p12, then p13) -> ARAT r7=p13; both old pregs freed.
- Assert a_rst_n low during RECOVER -> all outputs 0 immediately, IDLE and ready on release.
